dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, number of word-index bits (depth 2^ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default C::XLEN, word width in bits; multiple of 8, NB = DATA_WIDTH/8 byte lanes, OFS = log2(NB).
REQ-003 SHALL have port clk, input, 1, sole clock; all state on posedge clk.
REQ-004 SHALL have port rstn, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port wvalid, input, 1, store request valid.
REQ-006 SHALL have port wready, output, 1, store request accepted this cycle.
REQ-007 SHALL have port waddr, input, C::XLEN, store byte address.
REQ-008 SHALL have port wdata, input, DATA_WIDTH, store data, lane i = wdata[8i+7:8i].
REQ-009 SHALL have port wstrb, input, NB, per-lane store enable.
REQ-010 SHALL have port load_a_valid, input, 1, load request valid.
REQ-011 SHALL have port load_a_ready, output, 1, load request accepted this cycle.
REQ-012 SHALL have port load_a_addr, input, C::XLEN, load byte address.
REQ-013 SHALL have port load_d_valid, output, 1, load response valid; no back-pressure, initiator always accepts.
REQ-014 SHALL have port load_d_data, output, DATA_WIDTH, load response data.
REQ-015 SHALL have port err_o, output, 1, sticky out-of-range access flag.

Function
REQ-016 Handshake: transfer when valid && ready on same posedge; ready SHALL depend only on both valids and internal priority state, never on address/data.
REQ-017 At most one array access per cycle: only wvalid -> wready=1, load_a_ready=0; only load_a_valid -> load_a_ready=1, wready=0; neither -> both 0.
REQ-018 Both valid: grant by priority bit prio (0 = store wins, 1 = load wins); loser's ready = 0.
REQ-019 prio SHALL update only on a contended cycle (both valid): set to 1 after store win, 0 after load win; uncontended cycles leave it unchanged (round-robin, no starvation).
REQ-020 Word index = addr[ADDR_WIDTH+OFS-1:OFS]; addr[OFS-1:0] ignored (no misalignment fault).
REQ-021 Out-of-range: any addr bit at position >= ADDR_WIDTH+OFS nonzero.
REQ-022 Accepted in-range store: lanes with wstrb[i]=1 written at posedge of acceptance; other lanes unchanged; wstrb=0 is a legal no-op handshake.
REQ-023 Accepted out-of-range store: array unchanged, err_o set at next posedge.
REQ-024 Load latency exactly 1: load accepted at edge N -> load_d_valid=1 with data during cycle N..N+1 (registered, visible after edge N); load_d_valid=0 in any cycle without a load accepted on the previous edge.
REQ-025 Load data = array word as of acceptance edge, including every store accepted on earlier edges (serialized by REQ-017, no hazard).
REQ-026 Out-of-range load: response still issued with 1-cycle latency, load_d_data = 0, err_o set.
REQ-027 load_d_data SHALL hold its last value when load_d_valid=0.
REQ-028 Back-to-back loads one per cycle SHALL sustain full throughput (load_d_valid continuously 1).
REQ-029 err_o sticky: once 1, stays 1 until reset.

Reset
REQ-030 rstn=0 asynchronously forces load_d_valid=0, load_d_data=0, err_o=0, prio=0; wready and load_a_ready SHALL be 0 while rstn=0.
REQ-031 Array contents SHALL NOT be reset (undefined until written).
REQ-032 Load accepted on edge before reset assertion: no response after reset release; store accepted on last edge before reset is retained.
REQ-033 First edge after rstn deassertion SHALL accept requests normally.

Verification
REQ-034 Store waddr=0x10, wdata=0x1122334455667788, wstrb=0xFF; load 0x10 -> load_d_valid 1 cycle later, data 0x1122334455667788, err_o=0.
REQ-035 Then store 0x10 wdata=0xAAAA..., wstrb=0x01; load 0x13 -> data 0x11223344556677AA.
REQ-036 wvalid and load_a_valid held 1 for 4 cycles after reset -> grants store, load, store, load; prio alternates; load_d_valid 1 one cycle after each load grant.
REQ-037 Load addr = 1<<(ADDR_WIDTH+3) (DATA_WIDTH=64) -> load_d_data=0, load_d_valid=1, err_o=1 and stays 1 through 10 idle cycles.
REQ-038 Load accepted, rstn pulled low mid-cycle before next edge -> load_d_valid=0 immediately and after release; err_o=0.
REQ-039 8 consecutive loads to addresses 0x00..0x38 -> load_d_valid high 8 consecutive cycles, data in order.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder: arbitrated store / load channels,
// byte-lane stores, 1-cycle registered load response, sticky range error.
package C;
    parameter int XLEN = 64;
endpackage

module dmem_responder
    import C::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = C::XLEN
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [XLEN-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    load_a_valid,
    output logic                    load_a_ready,
    input  logic [XLEN-1:0]         load_a_addr,
    output logic                    load_d_valid,
    output logic [DATA_WIDTH-1:0]   load_d_data,
    output logic                    err_o
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);
    localparam int HI  = ADDR_WIDTH + OFS;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  prio;
    logic                  w_fire;
    logic                  l_fire;
    logic                  w_oor;
    logic                  l_oor;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] l_idx;
    logic                  unused_lsbs;

    assign w_idx = waddr[HI-1:OFS];
    assign l_idx = load_a_addr[HI-1:OFS];

    // Sub-word offset bits select nothing: accesses are whole-word.
    assign unused_lsbs = ^{waddr[OFS-1:0], load_a_addr[OFS-1:0]};

    generate
        if (HI < XLEN) begin : g_range
            assign w_oor = |waddr[XLEN-1:HI];
            assign l_oor = |load_a_addr[XLEN-1:HI];
        end else begin : g_full
            assign w_oor = 1'b0;
            assign l_oor = 1'b0;
        end
    endgenerate

    // Grant: one array access per cycle, prio breaks ties, nothing in reset.
    always_comb begin
        wready       = 1'b0;
        load_a_ready = 1'b0;
        if (rstn) begin
            wready       = wvalid && (!load_a_valid || !prio);
            load_a_ready = load_a_valid && (!wvalid || prio);
        end
    end

    assign w_fire = wvalid && wready;
    assign l_fire = load_a_valid && load_a_ready;

    // Round-robin: the loser of a contended cycle wins the next one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio <= 1'b0;
        end else if (wvalid && load_a_valid) begin
            prio <= w_fire;
        end
    end

    // Byte-lane array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_fire && !w_oor) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered load response; data holds between responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_d_valid <= 1'b0;
            load_d_data  <= '0;
        end else begin
            load_d_valid <= l_fire;
            if (l_fire) begin
                load_d_data <= l_oor ? '0 : mem[l_idx];
            end
        end
    end

    // Sticky error on any accepted out-of-range access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_o <= 1'b0;
        end else if ((w_fire && w_oor) || (l_fire && l_oor)) begin
            err_o <= 1'b1;
        end
    end

endmodule
